// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters.
// One operation in flight: accept -> wait for alu_ready -> hold response until taken.
package warp_pkg;
    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_MUL = 4'd2,
        OP_FMA = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6
    } alu_opcode_e;
endpackage

module alu_arbiter
    import warp_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  alu_opcode_e [NUM_REQ-1:0]        req_opcode,
    input  logic [NUM_REQ-1:0][31:0]         req_operand1,
    input  logic [NUM_REQ-1:0][31:0]         req_operand2,
    input  logic [NUM_REQ-1:0][31:0]         req_operand3,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [IDW-1:0]                   rsp_id,
    output logic [31:0]                      rsp_result,
    output logic                             rsp_overflow,
    output logic                             busy,
    output alu_opcode_e                      alu_opcode,
    output logic [31:0]                      alu_operand1,
    output logic [31:0]                      alu_operand2,
    output logic [31:0]                      alu_operand3,
    input  logic [31:0]                      alu_result,
    input  logic                             alu_overflow,
    input  logic                             alu_ready
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [IDW-1:0]     r_rr_ptr;
    logic               w_grant_vld;
    logic [IDW-1:0]     w_grant_idx;
    logic               w_accept;

    alu_opcode_e        r_alu_opcode;
    logic [31:0]        r_alu_operand1;
    logic [31:0]        r_alu_operand2;
    logic [31:0]        r_alu_operand3;
    logic               r_rsp_valid;
    logic [IDW-1:0]     r_rsp_id;
    logic [31:0]        r_rsp_result;
    logic               r_rsp_overflow;

    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base,
                                                input int unsigned   off);
        int unsigned sum;
        sum = 32'(base) + off;
        return IDW'(sum % NUM_REQ);
    endfunction

    // Search starts one past the last grant, so the last winner has lowest priority.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            if (!w_grant_vld && req_valid[wrap_add(r_rr_ptr, k)]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = wrap_add(r_rr_ptr, k);
            end
        end
    end

    assign w_accept  = (r_state == S_IDLE) && w_grant_vld;
    assign req_ready = w_accept ? (NUM_REQ'(1) << w_grant_idx) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_grant_vld) w_state_nxt = S_WAIT;
            S_WAIT:  if (alu_ready)   w_state_nxt = S_RESP;
            S_RESP:  if (rsp_ready)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr       <= IDW'(NUM_REQ - 1);
            r_alu_opcode   <= OP_ADD;
            r_alu_operand1 <= '0;
            r_alu_operand2 <= '0;
            r_alu_operand3 <= '0;
            r_rsp_valid    <= 1'b0;
            r_rsp_id       <= '0;
            r_rsp_result   <= '0;
            r_rsp_overflow <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_opcode   <= req_opcode[w_grant_idx];
                r_alu_operand1 <= req_operand1[w_grant_idx];
                r_alu_operand2 <= req_operand2[w_grant_idx];
                r_alu_operand3 <= req_operand3[w_grant_idx];
                r_rsp_id       <= w_grant_idx;
                r_rr_ptr       <= w_grant_idx;
            end
            if ((r_state == S_WAIT) && alu_ready) begin
                r_rsp_result   <= alu_result;
                r_rsp_overflow <= alu_overflow;
                r_rsp_valid    <= 1'b1;
            end
            if ((r_state == S_RESP) && r_rsp_valid && rsp_ready) begin
                r_rsp_valid    <= 1'b0;
            end
        end
    end

    assign busy         = (r_state != S_IDLE);
    assign alu_opcode   = r_alu_opcode;
    assign alu_operand1 = r_alu_operand1;
    assign alu_operand2 = r_alu_operand2;
    assign alu_operand3 = r_alu_operand3;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_result   = r_rsp_result;
    assign rsp_overflow = r_rsp_overflow;

endmodule
